// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_ZERO       = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } fetchState_t;

endpackage

// File: rtl/fetch_wdog.sv
// rtl/fetch_wdog.sv - REQ-cycle counter that flags an unanswered memory read
module fetch_wdog #(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // count holds the number of REQ cycles already completed, so the
  // TIMEOUT_CYC-th cycle is the one where it equals TIMEOUT_CYC-1
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYC - 1);

  logic [7:0] count;

  // count enabled cycles, restart whenever the fetch is not waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign expired = enable && (count == LAST_CNT);

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch unit owning PC and IR with imem req/ack handshake (option macro FETCH_ALIGN_CHECK_EN)
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned     TIMEOUT_CYC = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_req,
  input  logic            pc_load,
  input  logic [XLEN-1:0] pc_next,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ack,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            busy,
  output logic            fetch_err
);

  fetchState_t state, nextState;

  logic [XLEN-1:0] pcReg;      // address of the next word to fetch
  logic [XLEN-1:0] fetchPc;    // address of the word now held in instrReg
  logic [XLEN-1:0] instrReg;
  logic [XLEN-1:0] redirPc;
  logic            redirPending;
  logic            errFlag;
  logic            misaligned;
  logic            inReq;
  logic            wdogExpired;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = (pcReg[1:0] != 2'b00);
  assign imem_addr  = pcReg;
`else
  assign misaligned = 1'b0;
  assign imem_addr  = {pcReg[XLEN-1:2], 2'b00};
`endif

  assign inReq    = (state == REQ);
  assign instr    = instrReg;
  assign pc       = fetchPc;
  assign pc_plus4 = fetchPc + 32'd4;

  fetch_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) uWdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!inReq),
    .enable (inReq),
    .expired(wdogExpired)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // next state: a redirect in IDLE delays the fetch by one cycle
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (!pc_load && fetch_req) begin
          nextState = misaligned ? DONE : REQ;
        end
      end
      REQ: begin
        if (imem_ack || wdogExpired) begin
          nextState = DONE;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // outputs are pure decodes of the registered state
  always_comb begin
    imem_req    = 1'b0;
    busy        = 1'b0;
    instr_valid = 1'b0;
    fetch_err   = 1'b0;
    case (state)
      REQ: begin
        imem_req = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        busy        = 1'b1;
        instr_valid = 1'b1;
        fetch_err   = errFlag;
      end
      default: ;
    endcase
  end

  // PC, IR, redirect and error bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcReg        <= RESET_PC;
      fetchPc      <= RESET_PC;
      instrReg     <= INSTR_ZERO;
      redirPc      <= '0;
      redirPending <= 1'b0;
      errFlag      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pc_load) begin
            pcReg <= pc_next;
          end else if (fetch_req && misaligned) begin
            instrReg <= INSTR_ZERO;
            errFlag  <= 1'b1;
          end
        end
        REQ: begin
          if (imem_ack) begin
            instrReg     <= imem_rdata;
            fetchPc      <= pcReg;
            redirPending <= 1'b0;
            // a redirect arriving with the ack is the newest one and wins
            if (pc_load) begin
              pcReg <= pc_next;
            end else if (redirPending) begin
              pcReg <= redirPc;
            end else begin
              pcReg <= pcReg + 32'd4;
            end
          end else if (wdogExpired) begin
            // zero word makes the controller fall back to its reset state
            instrReg     <= INSTR_ZERO;
            errFlag      <= 1'b1;
            redirPending <= 1'b0;
          end else if (pc_load) begin
            redirPc      <= pc_next;
            redirPending <= 1'b1;
          end
        end
        DONE: begin
          errFlag <= 1'b0;
          if (pc_load) begin
            pcReg <= pc_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch with randomized fetch traffic
module tb_instr_fetch;

  localparam int          TO  = 15;
  localparam logic [31:0] RPC = 32'h0000_0000;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_next = 32'h0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req, instr_valid, busy, fetch_err;
  logic [31:0] imem_addr, instr, pc, pc_plus4;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] modelPc;
  logic [31:0] expFetchPc;

  instr_fetch #(.RESET_PC(RPC), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_req  (fetch_req),
    .pc_load    (pc_load),
    .pc_next    (pc_next),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .busy       (busy),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %b required %b", name, act, exp);
    end
  endtask

  // instruction memory contents: a fixed word at 0, an address hash elsewhere
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] randTgt();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
    if ($urandom_range(0, 5) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
    return t;
  endfunction

  // redirect in IDLE; optionally raised together with fetch_req
  task automatic loadPc(input logic [31:0] tgt, input bit withFetch);
    pc_load   = 1'b1;
    pc_next   = tgt;
    fetch_req = withFetch;
    @(posedge clk); #1;
    pc_load = 1'b0;
    checkBit("loadPrio", imem_req, 1'b0);
    modelPc = tgt;
  endtask

  // one fetch: ack after lat waiting cycles, up to two redirects during REQ, optional redirect in DONE
  task automatic doFetch(input int lat, input int r1c, input logic [31:0] r1t,
                         input int r2c, input logic [31:0] r2t,
                         input bit doneLoad, input logic [31:0] doneTgt);
    logic [31:0] expAddr, nextPc;
    int          expReq, nReq, best;
    bit          misal;
    exp_t        e;
    expAddr = ALIGN ? modelPc : {modelPc[31:2], 2'b00};
    misal   = ALIGN && (modelPc[1:0] != 2'b00);
    nextPc  = modelPc;
    if (misal) begin
      e.instr = 32'h0; e.pc = expFetchPc; e.err = 1'b1;
      expReq  = 0;
    end else if (lat < TO) begin
      e.instr = memWord(expAddr); e.pc = modelPc; e.err = 1'b0;
      expFetchPc = modelPc;
      expReq  = lat + 1;
      nextPc  = modelPc + 32'd4;
      best    = -1;
      if (r1c >= 0 && r1c < lat) begin nextPc = r1t; best = r1c; end
      if (r2c >= 0 && r2c < lat && r2c >= best) nextPc = r2t;
    end else begin
      e.instr = 32'h0; e.pc = expFetchPc; e.err = 1'b1;
      expReq  = TO;
    end
    expQ.push_back(e);

    fetch_req = 1'b1;
    @(posedge clk); #1;
    nReq = 0;
    while (!instr_valid && nReq < 40) begin
      checkBit("reqHigh", imem_req, 1'b1);
      check("addrStable", imem_addr, expAddr);
      checkBit("busyReq", busy, 1'b1);
      imem_ack   = (nReq == lat);
      imem_rdata = imem_ack ? memWord(imem_addr) : $urandom;
      if (nReq == r1c) begin pc_load = 1'b1; pc_next = r1t; end
      if (nReq == r2c) begin pc_load = 1'b1; pc_next = r2t; end
      @(posedge clk); #1;
      imem_ack = 1'b0;
      pc_load  = 1'b0;
      nReq++;
    end
    check("reqCycles", 32'(nReq), 32'(expReq));
    checkBit("validSeen", instr_valid, 1'b1);
    fetch_req = 1'b0;
    if (doneLoad) begin
      pc_load = 1'b1;
      pc_next = doneTgt;
      nextPc  = doneTgt;
    end
    @(posedge clk); #1;
    pc_load = 1'b0;
    checkBit("validPulse", instr_valid, 1'b0);
    checkBit("busyIdle", busy, 1'b0);
    modelPc = nextPc;
    // stray acks outside REQ must have no effect
    imem_ack   = 1'($urandom_range(0, 1));
    imem_rdata = $urandom;
    @(posedge clk); #1;
    imem_ack = 1'b0;
  endtask

  // monitor: compare every delivered instruction against the scoreboard
  initial begin
    logic [31:0] holdInstr;
    exp_t        m;
    holdInstr = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        holdInstr = 32'h0;
      end else if (instr_valid) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpectedValid: instr_valid 1 with nothing outstanding, required 0");
        end else begin
          m = expQ.pop_front();
          check("instr", instr, m.instr);
          check("pc", pc, m.pc);
          checkBit("fetchErr", fetch_err, m.err);
          check("pcPlus4", pc_plus4, m.pc + 32'd4);
          holdInstr = m.instr;
        end
      end else begin
        check("instrHold", instr, holdInstr);
        checkBit("errIdle", fetch_err, 1'b0);
      end
    end
  end

  initial begin
    modelPc    = RPC;
    expFetchPc = RPC;
    repeat (2) @(posedge clk);
    #1;
    check("rstPc", pc, RPC);
    check("rstInstr", instr, 32'h0);
    checkBit("rstValid", instr_valid, 1'b0);
    checkBit("rstImemReq", imem_req, 1'b0);
    checkBit("rstBusy", busy, 1'b0);
    checkBit("rstErr", fetch_err, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    doFetch(0, -1, 32'h0, -1, 32'h0, 1'b0, 32'h0);
    doFetch(5, -1, 32'h0, -1, 32'h0, 1'b0, 32'h0);
    doFetch(99, -1, 32'h0, -1, 32'h0, 1'b0, 32'h0);
    doFetch(3, 1, 32'h0000_0040, -1, 32'h0, 1'b0, 32'h0);
    doFetch(0, -1, 32'h0, -1, 32'h0, 1'b0, 32'h0);
    loadPc(32'hFFFF_FFFC, 1'b1);
    doFetch(0, -1, 32'h0, -1, 32'h0, 1'b0, 32'h0);
    doFetch(2, -1, 32'h0, -1, 32'h0, 1'b0, 32'h0);
    loadPc(32'h0000_0002, 1'b0);
    doFetch(0, -1, 32'h0, -1, 32'h0, 1'b0, 32'h0);
    doFetch(1, -1, 32'h0, -1, 32'h0, 1'b1, 32'h0000_0100);
    doFetch(0, -1, 32'h0, -1, 32'h0, 1'b0, 32'h0);

    for (int k = 0; k < 60; k++) begin
      int          lat, r1c, r2c;
      logic [31:0] t1, t2, td;
      bit          dl;
      if ($urandom_range(0, 3) == 0) loadPc(randTgt(), 1'($urandom_range(0, 1)));
      lat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(15, 20)) : int'($urandom_range(0, 14));
      r1c = -1;
      r2c = -1;
      t1  = randTgt();
      t2  = randTgt();
      td  = randTgt();
      if (lat > 0 && lat < TO) begin
        if ($urandom_range(0, 2) == 0) r1c = int'($urandom_range(0, lat - 1));
        if ($urandom_range(0, 3) == 0) r2c = int'($urandom_range(0, lat - 1));
      end
      dl = ($urandom_range(0, 5) == 0);
      doFetch(lat, r1c, t1, r2c, t2, dl, td);
    end

    // reset in the middle of a read
    loadPc(32'h0000_0020, 1'b0);
    fetch_req = 1'b1;
    @(posedge clk); #1;
    checkBit("rstPreReq", imem_req, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkBit("rstReqDrop", imem_req, 1'b0);
    checkBit("rstBusyDrop", busy, 1'b0);
    check("rstMidPc", pc, RPC);
    check("rstMidInstr", instr, 32'h0);
    fetch_req  = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    checkBit("lateAck", instr_valid, 1'b0);
    modelPc    = RPC;
    expFetchPc = RPC;
    doFetch(0, -1, 32'h0, -1, 32'h0, 1'b0, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    check("queueEmpty", 32'(expQ.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
